// File: rtl/rvfi_check_trigger.sv
// Fires a one-cycle check pulse when the target instruction retires on the
// watched RVFI channel inside the [MIN_CYCLES, MAX_CYCLES) window.
module rvfi_check_trigger #(
  parameter int NRET        = 1,
  parameter int CHANNEL_IDX = 0,
  parameter int MIN_CYCLES  = 4,
  parameter int MAX_CYCLES  = 32
) (
  input  logic              clock,
  input  logic              reset,
  input  logic [NRET-1:0]   rvfi_valid,
  input  logic [64*NRET-1:0] rvfi_order,
  input  logic [63:0]       target_order,
  output logic              check,
  output logic              pred_seen,
  output logic              missed,
  output logic              timeout,
  output logic              dup_error,
  output logic [15:0]       cycle_count,
  output logic [2:0]        fsm_state
);

  typedef enum logic [2:0] {
    WAIT_MIN = 3'd0,
    ARMED    = 3'd1,
    DONE     = 3'd2,
    MISSED   = 3'd3,
    TIMEOUT  = 3'd4
  } state_t;

  localparam logic [15:0]     MIN_LAST = 16'(MIN_CYCLES - 1);
  localparam logic [15:0]     MAX_LAST = 16'(MAX_CYCLES - 1);
  // Selects the channels strictly below CHANNEL_IDX; all zeros when it is 0.
  localparam logic [NRET-1:0] LOW_MASK = NRET'((64'd1 << CHANNEL_IDX) - 64'd1);

  state_t          state, state_next;
  logic [NRET-1:0] tgt_hit;
  logic [NRET-1:0] pred_hit;
  logic [63:0]     pred_order;
  logic            pred_seen_q;
  logic            dup_set;

  assign pred_order = target_order - 64'd1;

  always_comb begin
    tgt_hit  = '0;
    pred_hit = '0;
    for (int i = 0; i < NRET; i++) begin
      tgt_hit[i]  = rvfi_valid[i] && (rvfi_order[64*i +: 64] == target_order);
      // Order 0 has no predecessor, so the wrapped value must not match.
      pred_hit[i] = rvfi_valid[i] && (target_order != 64'd0) &&
                    (rvfi_order[64*i +: 64] == pred_order);
    end
  end

  always_comb begin
    state_next = state;
    check      = 1'b0;
    dup_set    = 1'b0;
    case (state)
      WAIT_MIN: begin
        if (|tgt_hit)                     state_next = MISSED;
        else if (cycle_count == MAX_LAST) state_next = TIMEOUT;
        else if (cycle_count == MIN_LAST) state_next = ARMED;
      end
      ARMED: begin
        // A hit on the watched channel wins over both miss and timeout.
        if (tgt_hit[CHANNEL_IDX]) begin
          check      = 1'b1;
          state_next = DONE;
        end else if (|tgt_hit) begin
          state_next = MISSED;
        end else if (cycle_count == MAX_LAST) begin
          state_next = TIMEOUT;
        end
      end
      DONE:    dup_set = |tgt_hit;
      default: state_next = state;
    endcase
    if (reset) check = 1'b0;
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state       <= WAIT_MIN;
      cycle_count <= 16'd0;
      pred_seen_q <= 1'b0;
      dup_error   <= 1'b0;
    end else begin
      state <= state_next;
      if (cycle_count != 16'hFFFF) cycle_count <= cycle_count + 16'd1;
      if (|pred_hit) pred_seen_q <= 1'b1;
      if (dup_set)   dup_error   <= 1'b1;
    end
  end

  assign pred_seen = pred_seen_q || |(pred_hit & LOW_MASK);
  assign missed    = (state == MISSED);
  assign timeout   = (state == TIMEOUT);
  assign fsm_state = state;

endmodule

// File: tb/tb_rvfi_check_trigger.sv
// Bench for rvfi_check_trigger: per-episode retirement tables, directed and
// random, compared cycle by cycle against a history-based reference model.
module tb_rvfi_check_trigger;
  localparam int NRET = 2;
  localparam int CH   = 1;
  localparam int MINC = 4;
  localparam int MAXC = 32;
  localparam int LMAX = 48;

  logic         clock = 1'b0;
  logic         reset;
  logic [1:0]   rvfi_valid;
  logic [127:0] rvfi_order;
  logic [63:0]  target_order;
  logic         check, pred_seen, missed, timeout, dup_error;
  logic [15:0]  cycle_count;
  logic [2:0]   fsm_state;

  always #5 clock = ~clock;

  rvfi_check_trigger #(
    .NRET(NRET), .CHANNEL_IDX(CH), .MIN_CYCLES(MINC), .MAX_CYCLES(MAXC)
  ) dut (
    .clock(clock), .reset(reset), .rvfi_valid(rvfi_valid),
    .rvfi_order(rvfi_order), .target_order(target_order), .check(check),
    .pred_seen(pred_seen), .missed(missed), .timeout(timeout),
    .dup_error(dup_error), .cycle_count(cycle_count), .fsm_state(fsm_state)
  );

  logic        val_tab [0:LMAX-1][0:1];
  logic [63:0] ord_tab [0:LMAX-1][0:1];
  logic [20:0] exp_q[$];
  int          n_vec = 0;
  int          n_err = 0;

  task automatic check_val(input string tag, input logic [63:0] got,
                           input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s @%0t: got %0h, want %0h", tag, $time, got, exp);
    end
  endtask

  function automatic bit tgt(int c, int ch);
    return val_tab[c][ch] && (ord_tab[c][ch] == target_order);
  endfunction

  function automatic bit pred(int c, int ch);
    return (target_order != 64'd0) && val_tab[c][ch] &&
           (ord_tab[c][ch] == target_order - 64'd1);
  endfunction

  // Expected {check, pred_seen, missed, timeout, dup_error, cycle_count}
  // for cycle c, derived from the whole episode's retirement history.
  function automatic logic [20:0] model(int c);
    int f = -1;
    bit in_window, fired, ck, ms, to, dp, ps;
    for (int g = 0; g < LMAX; g++)
      if (f < 0 && (tgt(g, 0) || tgt(g, 1))) f = g;
    in_window = (f >= 0) && (f <= MAXC - 1);
    fired = (f >= MINC) && (f <= MAXC - 1) && tgt(f, CH);
    ck = fired && (c == f);
    ms = in_window && !fired && (c > f);
    to = !in_window && (c >= MAXC);
    dp = 1'b0;
    if (fired)
      for (int g = f + 1; g < c; g++)
        if (tgt(g, 0) || tgt(g, 1)) dp = 1'b1;
    ps = pred(c, 0);
    for (int g = 0; g < c; g++)
      if (pred(g, 0) || pred(g, 1)) ps = 1'b1;
    return {ck, ps, ms, to, dp, 16'(c)};
  endfunction

  task automatic clear_tab();
    for (int c = 0; c < LMAX; c++)
      for (int ch = 0; ch < 2; ch++) begin
        val_tab[c][ch] = 1'b0;
        ord_tab[c][ch] = {$urandom(), $urandom()};
      end
  endtask

  task automatic put(input int c, input int ch, input logic [63:0] o);
    val_tab[c][ch] = 1'b1;
    ord_tab[c][ch] = o;
  endtask

  // Two reset cycles (target presented on the watched channel to prove check
  // is suppressed), then len cycles of table-driven retirements.
  task automatic run_episode(input int len);
    logic [20:0] e;
    reset      = 1'b1;
    rvfi_valid = 2'b10;
    rvfi_order = {target_order, 64'd0};
    @(negedge clock);
    check_val("rst_check", check, 0);
    @(posedge clock); #1;
    @(negedge clock);
    check_val("rst_check2", check, 0);
    check_val("rst_pred", pred_seen, 0);
    check_val("rst_missed", missed, 0);
    check_val("rst_timeout", timeout, 0);
    check_val("rst_dup", dup_error, 0);
    check_val("rst_count", cycle_count, 0);
    @(posedge clock); #1;
    reset = 1'b0;
    for (int c = 0; c < len; c++) begin
      rvfi_valid = {val_tab[c][1], val_tab[c][0]};
      rvfi_order = {ord_tab[c][1], ord_tab[c][0]};
      exp_q.push_back(model(c));
      @(negedge clock);
      e = exp_q.pop_front();
      check_val("check", check, e[20]);
      check_val("pred_seen", pred_seen, e[19]);
      check_val("missed", missed, e[18]);
      check_val("timeout", timeout, e[17]);
      check_val("dup_error", dup_error, e[16]);
      check_val("cycle_count", cycle_count, e[15:0]);
      @(posedge clock); #1;
    end
  endtask

  initial begin
    logic [63:0] o;
    int r;
    reset        = 1'b1;
    rvfi_valid   = '0;
    rvfi_order   = '0;
    target_order = 64'd10;

    // Predecessor then target, then a duplicate after firing.
    clear_tab(); put(5, 0, 9); put(7, 1, 10); put(9, 1, 10); run_episode(13);
    // Predecessor below the watched channel in the firing cycle.
    clear_tab(); put(6, 0, 9); put(6, 1, 10); run_episode(10);
    // Target before the window opens.
    clear_tab(); put(2, 1, 10); run_episode(10);
    // Never retires, then a late retirement after timeout.
    clear_tab(); put(35, 1, 10); run_episode(40);
    // Target on the wrong channel while armed.
    clear_tab(); put(6, 0, 10); run_episode(10);
    // Window edges: first armed cycle, last armed cycle, first timed-out cycle.
    clear_tab(); put(4, 1, 10); run_episode(8);
    clear_tab(); put(31, 1, 10); run_episode(36);
    clear_tab(); put(3, 0, 9); put(32, 1, 10); run_episode(36);
    // Both channels carry the target together; predecessor above the channel.
    clear_tab(); put(8, 0, 10); put(8, 1, 10); run_episode(12);
    clear_tab(); put(5, 1, 9); put(7, 1, 10); run_episode(10);
    // Target zero has no predecessor even though all-ones wraps onto it.
    target_order = 64'd0;
    clear_tab(); put(5, 0, 64'hFFFF_FFFF_FFFF_FFFF); put(5, 1, 0); run_episode(10);

    for (int ep = 0; ep < 25; ep++) begin
      target_order = ($urandom_range(0, 3) == 0) ? 64'd0 : {$urandom(), $urandom()};
      clear_tab();
      for (int c = 0; c < 36; c++)
        for (int ch = 0; ch < 2; ch++)
          if ($urandom_range(0, 1) == 1) begin
            r = $urandom_range(0, 15);
            if (r == 0)      o = target_order;
            else if (r < 3)  o = target_order - 64'd1;
            else if (r == 3) o = target_order + 64'd1;
            else             o = {$urandom(), $urandom()};
            put(c, ch, o);
          end
      run_episode(36);
    end

    clear_tab(); run_episode(0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
